// File: rtl/tdm_demux8x1.sv
// tdm_demux8x1: rebuilds 8 time-multiplexed channel slots into registered parallel outputs per frame
module tdm_demux8x1 #(
    parameter int WIDTH            = 1,
    parameter bit SYNC_EVERY_FRAME = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in,
    input  logic             sync,
    input  logic             enable,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic [WIDTH-1:0] out_c,
    output logic [WIDTH-1:0] out_d,
    output logic [WIDTH-1:0] out_e,
    output logic [WIDTH-1:0] out_f,
    output logic [WIDTH-1:0] out_g,
    output logic [WIDTH-1:0] out_h,
    output logic [2:0]       slot,
    output logic             locked,
    output logic             frame_valid,
    output logic             sync_error
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t           state, state_n;
    logic [2:0]       slot_n;
    logic             fv_n, se_n;
    logic [WIDTH-1:0] shadow [8];
    logic [WIDTH-1:0] shadow_n [8];
    logic [WIDTH-1:0] frame [8];
    logic [WIDTH-1:0] frame_n [8];
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            slot        <= 3'd0;
            shadow      <= '{default: '0};
            frame       <= '{default: '0};
            frame_valid <= 1'b0;
            sync_error  <= 1'b0;
        end else begin
            state       <= state_n;
            slot        <= slot_n;
            shadow      <= shadow_n;
            frame       <= frame_n;
            frame_valid <= fv_n;
            sync_error  <= se_n;
        end
    end
    // A stray sync restarts the frame at slot 0; a missing sync drops lock only when required
    always_comb begin
        state_n  = state;
        slot_n   = slot;
        shadow_n = shadow;
        frame_n  = frame;
        fv_n     = 1'b0;
        se_n     = 1'b0;
        if (enable) begin
            if (state == IDLE) begin
                if (sync) begin
                    shadow_n[0] = in;
                    slot_n      = 3'd1;
                    state_n     = RUN;
                end
            end else if (sync && slot != 3'd0) begin
                se_n        = 1'b1;
                shadow_n[0] = in;
                slot_n      = 3'd1;
            end else if (!sync && slot == 3'd0 && SYNC_EVERY_FRAME) begin
                se_n    = 1'b1;
                state_n = IDLE;
                slot_n  = 3'd0;
            end else begin
                shadow_n[slot] = in;
                slot_n         = slot + 3'd1;
                if (slot == 3'd7) begin
                    for (int i = 0; i < 7; i++) frame_n[i] = shadow[i];
                    frame_n[7] = in;
                    fv_n       = 1'b1;
                end
            end
        end
    end
    assign locked = (state == RUN);
    assign out_a  = frame[0];
    assign out_b  = frame[1];
    assign out_c  = frame[2];
    assign out_d  = frame[3];
    assign out_e  = frame[4];
    assign out_f  = frame[5];
    assign out_g  = frame[6];
    assign out_h  = frame[7];
endmodule

// File: tb/tb_tdm_demux8x1.sv
// tb_tdm_demux8x1: three demux variants driven in parallel and compared against a frame-buffer model
module tb_tdm_demux8x1;
    logic       clk = 1'b0, reset_n = 1'b0, enable = 1'b0, sync = 1'b0;
    logic [3:0] din = 4'd0;
    logic       o1 [8];
    logic [3:0] o0 [8];
    logic [3:0] o4 [8];
    logic [2:0] sl_1, sl_0, sl_4;
    logic       lk_1, lk_0, lk_4, fv_1, fv_0, fv_4, se_1, se_0, se_4;
    int         n_chk = 0, n_fail = 0;

    tdm_demux8x1 #(.WIDTH(1), .SYNC_EVERY_FRAME(1'b1)) u1 (
        .clk(clk), .reset_n(reset_n), .in(din[0:0]), .sync(sync), .enable(enable),
        .out_a(o1[0]), .out_b(o1[1]), .out_c(o1[2]), .out_d(o1[3]),
        .out_e(o1[4]), .out_f(o1[5]), .out_g(o1[6]), .out_h(o1[7]),
        .slot(sl_1), .locked(lk_1), .frame_valid(fv_1), .sync_error(se_1));
    tdm_demux8x1 #(.WIDTH(4), .SYNC_EVERY_FRAME(1'b0)) u0 (
        .clk(clk), .reset_n(reset_n), .in(din), .sync(sync), .enable(enable),
        .out_a(o0[0]), .out_b(o0[1]), .out_c(o0[2]), .out_d(o0[3]),
        .out_e(o0[4]), .out_f(o0[5]), .out_g(o0[6]), .out_h(o0[7]),
        .slot(sl_0), .locked(lk_0), .frame_valid(fv_0), .sync_error(se_0));
    tdm_demux8x1 #(.WIDTH(4), .SYNC_EVERY_FRAME(1'b1)) u4 (
        .clk(clk), .reset_n(reset_n), .in(din), .sync(sync), .enable(enable),
        .out_a(o4[0]), .out_b(o4[1]), .out_c(o4[2]), .out_d(o4[3]),
        .out_e(o4[4]), .out_f(o4[5]), .out_g(o4[6]), .out_h(o4[7]),
        .slot(sl_4), .locked(lk_4), .frame_valid(fv_4), .sync_error(se_4));

    always #5 clk = ~clk;

    // model: per instance, the slots gathered so far in the current frame plus the last full frame
    int         mlen [3];
    bit         mlock [3], mfv [3], mse [3];
    logic [3:0] mbuf [3][8];
    logic [3:0] mout [3][8];

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            mlen[k] = 0; mlock[k] = 0; mfv[k] = 0; mse[k] = 0;
            for (int i = 0; i < 8; i++) begin mbuf[k][i] = 4'd0; mout[k][i] = 4'd0; end
        end
    endtask

    task automatic model_step(input bit e, input bit s, input logic [3:0] d);
        logic [3:0] v;
        bit         need_sync;
        for (int k = 0; k < 3; k++) begin
            mfv[k] = 0; mse[k] = 0;
            v = (k == 0) ? {3'b000, d[0]} : d;
            need_sync = (k != 1);
            if (!e) continue;
            if (!mlock[k]) begin
                if (s) begin mbuf[k][0] = v; mlen[k] = 1; mlock[k] = 1; end
            end else if (s && mlen[k] != 0) begin
                mse[k] = 1; mbuf[k][0] = v; mlen[k] = 1;
            end else if (!s && mlen[k] == 0 && need_sync) begin
                mse[k] = 1; mlock[k] = 0;
            end else begin
                mbuf[k][mlen[k]] = v;
                mlen[k]++;
                if (mlen[k] == 8) begin
                    mout[k] = mbuf[k];
                    mfv[k] = 1;
                    mlen[k] = 0;
                end
            end
        end
    endtask

    function automatic logic [37:0] obs(input int k);
        logic [31:0] o;
        for (int i = 0; i < 8; i++) o[31-4*i -: 4] = (k == 0) ? {3'b000, o1[i]} : (k == 1) ? o0[i] : o4[i];
        if (k == 0) return {sl_1, lk_1, fv_1, se_1, o};
        if (k == 1) return {sl_0, lk_0, fv_0, se_0, o};
        return {sl_4, lk_4, fv_4, se_4, o};
    endfunction

    function automatic logic [37:0] expv(input int k);
        logic [31:0] o;
        for (int i = 0; i < 8; i++) o[31-4*i -: 4] = mout[k][i];
        return {3'(mlen[k]), mlock[k], mfv[k], mse[k], o};
    endfunction

    task automatic drive(input bit e, input bit s, input logic [3:0] d);
        @(negedge clk);
        enable = e; sync = s; din = d;
        @(posedge clk);
        model_step(e, s, d);
        #1;
    endtask

    function automatic logic [7:0] out1();
        return {o1[0], o1[1], o1[2], o1[3], o1[4], o1[5], o1[6], o1[7]};
    endfunction

    task automatic test_reset();
        reset_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            n_chk++;
            if (obs(k) !== expv(k)) begin n_fail++; $display("FAIL reset inst%0d got=%h exp=%h", k, obs(k), expv(k)); end
        end
        reset_n = 1'b1;
        drive(1'b1, 1'b0, 4'd5);
        for (int k = 0; k < 3; k++) begin
            n_chk++;
            if (obs(k) !== expv(k)) begin n_fail++; $display("FAIL idle_nosync inst%0d got=%h exp=%h", k, obs(k), expv(k)); end
        end
    endtask

    task automatic test_frame();
        logic [7:0] pat = 8'b1011_0010;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, i == 0, {3'($urandom), pat[7-i]});
            for (int k = 0; k < 3; k++) begin
                n_chk++;
                if (obs(k) !== expv(k)) begin n_fail++; $display("FAIL frame inst%0d got=%h exp=%h", k, obs(k), expv(k)); end
            end
        end
        n_chk++;
        if ({fv_1, lk_1, sl_1, out1()} !== {1'b1, 1'b1, 3'd0, 8'b1011_0010}) begin
            n_fail++; $display("FAIL frame_literal got=%b exp=%b", {fv_1, lk_1, sl_1, out1()}, {1'b1, 1'b1, 3'd0, 8'b1011_0010});
        end
    endtask

    task automatic test_stall();
        logic [7:0] pat = 8'b1011_0010;
        for (int i = 0; i < 11; i++) begin
            if (i >= 5 && i < 8) drive(1'b0, 1'($urandom), 4'($urandom));
            else drive(1'b1, i == 0, {3'($urandom), pat[7-(i < 5 ? i : i - 3)]});
            if (i >= 5 && i < 8) begin
                n_chk++;
                if ({sl_1, fv_1} !== {3'd5, 1'b0}) begin n_fail++; $display("FAIL stall_hold slot=%0d fv=%b exp slot=5 fv=0", sl_1, fv_1); end
            end
            for (int k = 0; k < 3; k++) begin
                n_chk++;
                if (obs(k) !== expv(k)) begin n_fail++; $display("FAIL stall inst%0d got=%h exp=%h", k, obs(k), expv(k)); end
            end
        end
        n_chk++;
        if ({fv_1, out1()} !== {1'b1, 8'b1011_0010}) begin n_fail++; $display("FAIL stall_literal got=%b exp=%b", {fv_1, out1()}, {1'b1, 8'b1011_0010}); end
    endtask

    task automatic test_midsync();
        for (int i = 0; i < 11; i++) begin
            drive(1'b1, i == 0 || i == 3, 4'($urandom));
            if (i == 3) begin
                n_chk++;
                if ({se_1, sl_1, fv_1} !== {1'b1, 3'd1, 1'b0}) begin n_fail++; $display("FAIL midsync_err got=%b exp=%b", {se_1, sl_1, fv_1}, {1'b1, 3'd1, 1'b0}); end
            end
            for (int k = 0; k < 3; k++) begin
                n_chk++;
                if (obs(k) !== expv(k)) begin n_fail++; $display("FAIL midsync inst%0d got=%h exp=%h", k, obs(k), expv(k)); end
            end
        end
        n_chk++;
        if (fv_4 !== 1'b1) begin n_fail++; $display("FAIL midsync_complete fv=%b exp=1", fv_4); end
    endtask

    task automatic test_missing_sync();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0, 4'($urandom));
            if (i == 0) begin
                n_chk++;
                if ({se_1, lk_1, se_0, lk_0} !== 4'b1001) begin n_fail++; $display("FAIL nosync_first got=%b exp=1001", {se_1, lk_1, se_0, lk_0}); end
            end
            for (int k = 0; k < 3; k++) begin
                n_chk++;
                if (obs(k) !== expv(k)) begin n_fail++; $display("FAIL nosync inst%0d got=%h exp=%h", k, obs(k), expv(k)); end
            end
        end
        n_chk++;
        if ({fv_0, fv_4} !== 2'b10) begin n_fail++; $display("FAIL nosync_frame got=%b exp=10", {fv_0, fv_4}); end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 5; i++) drive(1'b1, i == 0, 4'($urandom_range(1, 15)));
        #2 reset_n = 1'b0;
        model_reset();
        #1;
        for (int k = 0; k < 3; k++) begin
            n_chk++;
            if (obs(k) !== expv(k)) begin n_fail++; $display("FAIL async_reset inst%0d got=%h exp=%h", k, obs(k), expv(k)); end
        end
        @(negedge clk) reset_n = 1'b1;
        for (int i = 0; i < 11; i++) begin
            drive(1'b1, i == 3, 4'($urandom));
            for (int k = 0; k < 3; k++) begin
                n_chk++;
                if (obs(k) !== expv(k)) begin n_fail++; $display("FAIL post_reset inst%0d got=%h exp=%h", k, obs(k), expv(k)); end
            end
        end
    endtask

    task automatic test_back_to_back();
        int n_fv = 0;
        for (int f = 0; f < 16; f++) begin
            for (int s = 0; s < 8; s++) begin
                drive(1'b1, s == 0, 4'($urandom));
                n_fv += int'(fv_4);
                for (int k = 0; k < 3; k++) begin
                    n_chk++;
                    if (obs(k) !== expv(k)) begin n_fail++; $display("FAIL b2b inst%0d got=%h exp=%h", k, obs(k), expv(k)); end
                end
            end
        end
        n_chk++;
        if (n_fv != 16) begin n_fail++; $display("FAIL b2b_count got=%0d exp=16", n_fv); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 4) != 0, $urandom_range(0, 9) == 0 || (mlen[2] == 0 && $urandom_range(0, 3) != 0), 4'($urandom));
            for (int k = 0; k < 3; k++) begin
                n_chk++;
                if (obs(k) !== expv(k)) begin n_fail++; $display("FAIL random inst%0d got=%h exp=%h", k, obs(k), expv(k)); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_stall();
        test_midsync();
        test_missing_sync();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
